// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants for the key debounce/pulse filter
package key_pkg;

  localparam int   DEB_CYCLES_DEF  = 240000;
  localparam int   HOLD_CYCLES_DEF = 12000000;
  localparam logic KEY_RELEASED    = 1'b1;

endpackage

// File: rtl/key_filter_cell.sv
// rtl/key_filter_cell.sv - one key: synchronizer, debounce counter, hold counter, event pulses
module key_filter_cell
  import key_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_pulse,
  output logic key_release,
  output logic key_state,
  output logic key_hold
);

  localparam int              DW        = $clog2(DEB_CYCLES) + 1;
  localparam int              HW        = $clog2(HOLD_CYCLES) + 1;
  localparam logic [DW-1:0]   DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]   HOLD_SAT  = HW'(HOLD_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_state;
  logic [DW-1:0] r_deb_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic          r_pulse;
  logic          r_release;
  logic          r_hold;

  logic          w_differ;
  logic          w_deb_done;

  assign w_differ   = (r_sync2 != r_state);
  assign w_deb_done = (r_deb_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= KEY_RELEASED;
      r_sync2 <= KEY_RELEASED;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  // Any sample matching the accepted level throws away all accumulated credit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb_cnt <= '0;
      r_state   <= KEY_RELEASED;
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
      if (!w_differ) begin
        r_deb_cnt <= '0;
      end else if (w_deb_done) begin
        r_deb_cnt <= '0;
        r_state   <= r_sync2;
        r_pulse   <= ~r_sync2;
        r_release <= r_sync2;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end
  end

  // Counter parks one past the hold point so the hold flag fires once per press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_cnt <= '0;
      r_hold     <= 1'b0;
    end else if (r_state == KEY_RELEASED) begin
      r_hold_cnt <= '0;
      r_hold     <= 1'b0;
    end else begin
      r_hold <= (r_hold_cnt == HOLD_LAST);
      if (r_hold_cnt != HOLD_SAT) begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end
    end
  end

  assign key_pulse   = r_pulse;
  assign key_release = r_release;
  assign key_state   = r_state;
  assign key_hold    = r_hold;

endmodule

// File: rtl/key_filter_pulse.sv
// rtl/key_filter_pulse.sv - N independent debounced keys with press/release/hold pulses
module key_filter_pulse
  import key_pkg::*;
#(
  parameter int N           = 1,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_pulse,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_state,
  output logic [N-1:0] key_hold
);

  for (genvar g = 0; g < N; g++) begin : g_key
    key_filter_cell #(
      .DEB_CYCLES  (DEB_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .key         (key[g]),
      .key_pulse   (key_pulse[g]),
      .key_release (key_release[g]),
      .key_state   (key_state[g]),
      .key_hold    (key_hold[g])
    );
  end

endmodule

// File: doc/key_filter_pulse.md
KEY_FILTER_PULSE -- requirements
Module: key_filter_pulse

Interface
REQ-001 SHALL have parameter N, default 1: number of independent keys.
REQ-002 SHALL have parameter DEB_CYCLES, default 240000: stable-sample count before a level is accepted (20 ms at 12 MHz).
REQ-003 SHALL have parameter HOLD_CYCLES, default 12000000: accepted-low duration that flags a long press (1 s at 12 MHz).
REQ-004 SHALL have port clk  input  1: single system clock; all flops on rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port key  input  N: raw asynchronous push-buttons, active-low (0 = pressed).
REQ-007 SHALL have port key_pulse  output  N: one-cycle high per accepted press.
REQ-008 SHALL have port key_release  output  N: one-cycle high per accepted release.
REQ-009 SHALL have port key_state  output  N: debounced level, active-low, same polarity as key.
REQ-010 SHALL have port key_hold  output  N: one-cycle high when a press has lasted HOLD_CYCLES.

Function
REQ-011 SHALL pass each key bit through a two-flop synchronizer before any other logic.
REQ-012 SHALL keep per-key debounce counter of width clog2(DEB_CYCLES)+1, cleared every cycle synchronized input equals key_state.
REQ-013 SHALL increment the counter while synchronized input differs from key_state; on the cycle count equals DEB_CYCLES-1 it SHALL load key_state with the synchronized input and clear the counter.
REQ-014 SHALL restart debouncing from zero on any bounce (input returning to key_state) before DEB_CYCLES is reached; no partial credit.
REQ-015 SHALL assert key_pulse[i] for exactly one cycle, coincident with the first cycle key_state[i] reads 0.
REQ-016 SHALL assert key_release[i] for exactly one cycle, coincident with the first cycle key_state[i] reads 1.
REQ-017 SHALL give latency from first cycle raw key stably changed to key_state change of exactly DEB_CYCLES+2 rising edges.
REQ-018 SHALL keep per-key hold counter (width clog2(HOLD_CYCLES)+1) running only while key_state is 0, cleared on key_state 1.
REQ-019 SHALL assert key_hold[i] for one cycle when hold counter reaches HOLD_CYCLES-1, then saturate; at most one key_hold per press.
REQ-020 SHALL treat keys fully independently; simultaneous events on several keys SHALL produce simultaneous pulses with no priority or loss.
REQ-021 SHALL never assert key_pulse and key_release of one key in the same cycle.

Reset
REQ-022 SHALL on rst low, immediately and asynchronously: synchronizer flops and key_state to all 1s, all counters 0, key_pulse, key_release, key_hold 0.
REQ-023 SHALL, if a key is held low through reset release, report it as a new press after DEB_CYCLES+2 edges (one key_pulse, no key_release first).
REQ-024 SHALL abandon any in-progress debounce or hold count on reset mid-operation without emitting a pulse.

Structure
REQ-025 SHALL place default DEB_CYCLES, HOLD_CYCLES and the released level (1) as constants in shared package key_pkg.
REQ-026 SHALL implement one key as sub-module key_filter_cell (synchronizer, two counters, edge/hold pulses), instantiated N times in a generate loop.
REQ-027 SHALL drive outputs directly from flops; no combinational path from key to any output.

Verification (DEB_CYCLES=4, HOLD_CYCLES=10, N=2)
REQ-028 SHALL cover clean press: key[0] 1->0 held -> key_pulse[0] high one cycle at edge 6, key_state[0]=0 thereafter, key[1] outputs unchanged.
REQ-029 SHALL cover bounce: key[0] low 3 cycles, high 1, low steady -> no pulse during bounce; single key_pulse 6 edges after last falling transition.
REQ-030 SHALL cover long press: key[0] low 20 cycles then high -> one key_pulse, one key_hold 10 cycles after key_state falls, one key_release 6 edges after raw rise.
REQ-031 SHALL cover simultaneous: key=2'b11->2'b00 same cycle -> key_pulse=2'b11 in same cycle.
REQ-032 SHALL cover reset mid-debounce: key[0] low 2 cycles, rst low 1 cycle, key[0] stays low -> no pulse during reset, key_pulse 6 edges after rst deasserts, key_release never asserted.
